// File: rtl/instr_encoder_loader.sv
// Packs symbolic MIPS instruction descriptors into 32-bit machine words and
// writes them to consecutive imem addresses over an acknowledged write port.
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic              last_reg, last_next;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              full_int;
  logic              accept;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_kind)
      4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      4'd3:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      4'd4:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      4'd5:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'b000101, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd10:   enc_word = {6'b001010, in_rs, in_rt, in_imm};
      4'd11:   enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd12:   enc_word = {6'b000010, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign full_int = (count_reg == CNT_W'(DEPTH));
  assign in_ready = (state_reg == IDLE) && !full_int;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    wdata_next = wdata_reg;
    err_next   = err_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (enc_legal) begin
            wdata_next = enc_word;
            last_next  = in_last;
            state_next = WRITE;
          end else begin
            err_next = 1'b1;
            if (in_last) begin
              state_next = DONE;
            end
          end
        end
      end
      WRITE: begin
        if (imem_ack) begin
          count_next = count_reg + CNT_W'(1);
          // Saturate at the last slot instead of wrapping to 0 once full.
          if (count_reg < CNT_W'(DEPTH - 1)) begin
            addr_next = addr_reg + ADDR_W'(1);
          end
          state_next = last_reg ? DONE : IDLE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Soft clear beats a same-cycle ack: that write is dropped from the count.
    if (clear) begin
      state_next = IDLE;
      addr_next  = '0;
      count_next = '0;
      wdata_next = 32'h0;
      err_next   = 1'b0;
      last_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      wdata_reg <= 32'h0;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      last_reg  <= last_next;
    end
  end

  assign imem_we    = (state_reg == WRITE);
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign count      = count_reg;
  assign full       = full_int;
  assign err        = err_reg;
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_kind = 4'd0;
  logic [4:0]        in_rs = 5'd0;
  logic [4:0]        in_rt = 5'd0;
  logic [4:0]        in_rd = 5'd0;
  logic [15:0]       in_imm = 16'h0;
  logic [25:0]       in_target = 26'h0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              err;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .count(count), .full(full), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  // Encoding straight from the opcode/funct tables, built with arithmetic.
  function automatic logic [32:0] model_encode(int kind, longint rs, longint rt,
                                               longint rd, longint imm, longint tgt);
    longint op;
    longint funct;
    longint w;
    op = 0;
    funct = 0;
    case (kind)
      0: funct = 32;
      1: funct = 34;
      2: funct = 36;
      3: funct = 37;
      4: funct = 42;
      5: op = 35;
      6: op = 43;
      7: op = 4;
      8: op = 5;
      9: op = 8;
      10: op = 10;
      11: op = 13;
      12: op = 2;
      default: return 33'h0;
    endcase
    if (kind <= 4) w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct;
    else if (kind == 12) w = op * (1 << 26) + tgt;
    else w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    return {1'b1, w[31:0]};
  endfunction

  // Transaction-level model: one outstanding write at most, plus sticky flags.
  bit          m_valid = 0;
  bit          m_busy, m_done, m_err, m_last;
  int          m_count;
  logic [31:0] m_word;
  int          cyc = 0;

  always @(negedge clk) begin
    bit bad;
    logic [32:0] r;
    cyc++;
    if (m_valid) begin
      bad = 0;
      if (imem_we !== m_busy) bad = 1;
      if (in_ready !== (!m_busy && !m_done && m_count < DEPTH)) bad = 1;
      if (m_busy && imem_wdata !== m_word) bad = 1;
      if (!m_busy && imem_wdata !== m_word) bad = 1;
      if (m_count < DEPTH && imem_addr !== ADDR_W'(m_count)) bad = 1;
      if (count !== CNT_W'(m_count)) bad = 1;
      if (full !== (m_count == DEPTH)) bad = 1;
      if (err !== m_err) bad = 1;
      if (done !== m_done) bad = 1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL model cycle %0d (dut/model): we %b/%b ready %b/%b addr %0d/%0d data %h/%h count %0d/%0d full %b/%b err %b/%b done %b/%b",
                 cyc, imem_we, m_busy, in_ready, (!m_busy && !m_done && m_count < DEPTH),
                 imem_addr, m_count, imem_wdata, m_word, count, m_count,
                 full, (m_count == DEPTH), err, m_err, done, m_done);
      end
    end
    if (reset || clear) begin
      m_valid = m_valid || reset;
      m_busy = 0; m_done = 0; m_err = 0; m_last = 0; m_count = 0; m_word = 32'h0;
    end else if (m_busy) begin
      if (imem_ack) begin
        m_count++;
        m_busy = 0;
        m_done = m_last;
      end
    end else if (!m_done && in_valid && m_count < DEPTH) begin
      r = model_encode(int'(in_kind), longint'(in_rs), longint'(in_rt), longint'(in_rd),
                       longint'(in_imm), longint'(in_target));
      if (r[32]) begin
        m_busy = 1;
        m_word = r[31:0];
        m_last = in_last;
      end else begin
        m_err = 1;
        if (in_last) m_done = 1;
      end
    end
  end

  // Log of completed writes.
  int          log_addr[$];
  logic [31:0] log_data[$];
  always @(negedge clk) begin
    if (imem_we && imem_ack) begin
      log_addr.push_back(int'(imem_addr));
      log_data.push_back(imem_wdata);
    end
  end

  // Memory responder: fixed ack latency, or random acks during soak.
  bit ack_rand = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ack_rand) begin
      imem_ack = ($urandom_range(0, 2) == 0);
    end else if (imem_we) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int kind, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit last,
                      input int limit, output bit ok);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_kind = 4'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!imem_we) begin
        ok = 1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: imem_we still 1 after 60 cycles, expected 0");
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", in_ready, 1);
    chk("reset_we", imem_we, 0);
    chk("reset_count", count, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_wdata", imem_wdata, 0);
    chk("reset_flags", {full, err, done}, 0);

    // ADD with immediate ack
    ack_delay = 0;
    send(0, 1, 2, 3, $urandom, $urandom, 0, 10, ok);
    chk("add_accept", ok, 1);
    wait_idle();
    chk("add_nwrites", log_data.size(), 1);
    chk("add_word", log_data[0], 32'h00221820);
    chk("add_addr", log_addr[0], 0);
    chk("add_count", count, 1);

    // LW / BNE / J(last) with 3-cycle ack stall
    pulse_clear();
    ack_delay = 3;
    send(5, 0, 8, $urandom, 16'h0004, $urandom, 0, 10, ok);
    chk("lw_accept", ok, 1);
    @(negedge clk);
    chk("lw_stall_we", imem_we, 1);
    chk("lw_stall_data", imem_wdata, 32'h8C080004);
    @(negedge clk);
    chk("lw_stall_data2", imem_wdata, 32'h8C080004);
    wait_idle();
    send(8, 8, 0, $urandom, 16'hFFFE, $urandom, 0, 10, ok);
    chk("bne_accept", ok, 1);
    wait_idle();
    send(12, $urandom, $urandom, $urandom, $urandom, 26'h0000010, 1, 10, ok);
    chk("j_accept", ok, 1);
    wait_idle();
    chk("seq_nwrites", log_data.size(), 3);
    chk("seq_word0", log_data[0], 32'h8C080004);
    chk("seq_word1", log_data[1], 32'h1500FFFE);
    chk("seq_word2", log_data[2], 32'h08000010);
    chk("seq_addr2", log_addr[2], 2);
    chk("seq_done", done, 1);
    chk("seq_ready", in_ready, 0);

    // Illegal kind, then ORI
    pulse_clear();
    ack_delay = 0;
    send(14, 1, 2, 3, 4, 5, 0, 10, ok);
    @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_we", imem_we, 0);
    chk("ill_addr", imem_addr, 0);
    send(11, 1, 1, $urandom, 16'h00FF, $urandom, 0, 10, ok);
    wait_idle();
    chk("ori_nwrites", log_data.size(), 1);
    chk("ori_word", log_data[0], 32'h342100FF);
    chk("ori_addr", log_addr[0], 0);

    // Fill to DEPTH; the extra descriptor must never be taken
    pulse_clear();
    for (int k = 0; k < DEPTH + 1; k++) begin
      send(9, k, k + 1, 0, k * 3, 0, 0, 10, ok);
      if (k < DEPTH) begin
        chk("fill_accept", ok, 1);
        wait_idle();
      end else begin
        chk("fill_refused", ok, 0);
      end
    end
    chk("fill_nwrites", log_data.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++) chk("fill_addr", log_addr[k], k);
    chk("fill_word3", log_data[3], 32'h20640009);
    chk("fill_full", full, 1);
    chk("fill_ready", in_ready, 0);

    // Reset, then clear, while a write is stalled
    for (int which = 0; which < 2; which++) begin
      pulse_clear();
      ack_delay = 0;
      send(3, 4, 5, 6, 0, 0, 0, 10, ok);
      wait_idle();
      send(15, 0, 0, 0, 0, 0, 0, 10, ok);
      ack_delay = 1000;
      send(1, 7, 8, 9, 0, 0, 0, 10, ok);
      repeat (2) @(negedge clk);
      chk("stall_pre_we", imem_we, 1);
      chk("stall_pre_cnt", count, 1);
      @(posedge clk); #1;
      if (which == 0) reset = 1'b1; else clear = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; clear = 1'b0;
      chk(which == 0 ? "rst_we" : "clr_we", imem_we, 0);
      chk(which == 0 ? "rst_count" : "clr_count", count, 0);
      chk(which == 0 ? "rst_addr" : "clr_addr", imem_addr, 0);
      chk(which == 0 ? "rst_err" : "clr_err", err, 0);
      chk(which == 0 ? "rst_ready" : "clr_ready", in_ready, 1);
    end

    // clear coinciding with ack
    ack_delay = 0;
    pulse_clear();
    send(4, 1, 1, 1, 0, 0, 0, 10, ok);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clrack_we", imem_we, 0);
    chk("clrack_count", count, 0);
    chk("clrack_addr", imem_addr, 0);

    // Randomized soak
    ack_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_kind   = 4'($urandom_range(0, 15));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      in_last   = ($urandom_range(0, 11) == 0);
    end
    @(posedge clk); #1;
    ack_rand = 0;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential MIPS instruction encoder and instruction-memory loader, the inverse of the opcode decoder. It accepts symbolic instruction descriptors (class plus register, immediate and target fields) over a valid/ready handshake and packs each one into a 32-bit MIPS machine word. It writes the words to consecutive instruction-memory addresses over an acknowledged write port. The block is used by the bench and bring-up logic to fill imem before the pipelined core is released from reset, and encodes exactly the opcode set the core decodes.

## Interface
Parameters:
- ADDR_W, 6, imem word-address width
- DEPTH, 64, number of writable words (≤ 2**ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft clear: addr/count/err to 0, FSM to IDLE
- in_valid  in  1  descriptor valid
- in_ready  out  1  block can accept a descriptor
- in_kind  in  4  instruction class: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 ADDI, 10 SLTI, 11 ORI, 12 J, 13–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- in_last  in  1  descriptor is the final one of the program
- imem_we  out  1  write request
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- imem_ack  in  1  memory accepted the write this cycle
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  count == DEPTH
- err  out  1  sticky: an illegal kind was received
- done  out  1  last descriptor has been written

## Operation
- Encoding:
  - R-type: op=000000, rs, rt, rd, shamt=0, funct ADD 100000 / SUB 100010 / AND 100100 / OR 100101 / SLT 101010.
  - I-type: {op, rs, rt, imm} with op LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ORI 001101.
  - J: {000010, target}.
  - Unused descriptor fields are ignored.
- FSM states:
  - IDLE: in_ready = !full. On in_valid&&in_ready, capture the descriptor.
    - Legal kind → WRITE with imem_wdata registered.
    - Illegal kind → err set, no write; in_last → DONE, else stay IDLE.
  - WRITE: imem_we=1, imem_addr and imem_wdata held stable until imem_ack. On ack: imem_addr+1, count+1, then → DONE if the captured in_last was set, else → IDLE.
  - DONE: done=1, in_ready=0. Exit only via clear or reset.
- Address never wraps. When count reaches DEPTH, full=1, in_ready=0, FSM stays IDLE. No write is issued beyond DEPTH−1.
- clear takes precedence over everything except reset, including an ack arriving in the same cycle: that write is not counted and the address returns to 0.
- reset (sync) overrides all: every register returns to its reset value, even mid-WRITE.

## Timing
- Reset/clear values:
  - state IDLE
  - imem_we=0, imem_addr=0, imem_wdata=0
  - count=0, full=0, err=0, done=0
  - in_ready=1 (combinational from state/full)
- Accept in cycle N → imem_we=1 from cycle N+1.
- Ack in cycle M → in cycle M+1: imem_we=0, addr/count updated, in_ready=1 (if not full and not done).
- Throughput: at most one word per 2 cycles (accept cycle + ack cycle when ack is immediate).
- in_ready is low throughout WRITE, so no descriptor is accepted while a write is outstanding.
- imem_ack while imem_we=0 is ignored.
- Illegal descriptor: err=1 from N+1; addr and count unchanged.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 with ack in the same cycle as imem_we → imem_wdata=0x00221820 at addr 0; count=1 after the ack.
- Sequence LW rs=0 rt=8 imm=0x0004, BNE rs=8 rt=0 imm=0xFFFE, J target=0x0000010 (in_last), with ack delayed 3 cycles each → words 0x8C080004, 0x1500FFFE, 0x08000010 at addrs 0..2; imem_we and data held stable during the stall; done=1 after the third ack; in_ready=0 afterwards.
- in_kind=14 → err=1, no imem_we, addr stays 0; following ORI rs=1 rt=1 imm=0x00FF → 0x342100FF at addr 0.
- DEPTH=4: issue 5 legal descriptors → 4 writes at addrs 0..3, full=1, in_ready=0, 5th never accepted.
- Assert reset, and separately clear, while in WRITE with ack withheld → next cycle imem_we=0, count=0, addr=0, err=0, state IDLE.
- clear asserted in the same cycle as imem_ack → count stays 0, addr=0.
